// File: rtl/upsample2x_stream.sv
// upsample2x_stream: 2x nearest-neighbour upsampler for a raster feature-map stream.
// Each input pixel is emitted twice on the first output row; the row is then replayed from a line buffer.
// Ready/valid on both sides: outputs hold steady under out_ready=0, and in_ready drops while a row is replayed.
module upsample2x_stream #(
  parameter int IN_WIDTH   = 14,
  parameter int IN_HEIGHT  = 14,
  parameter int CHANNELS   = 256,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
  localparam int RW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int KW = (CHANNELS  > 1) ? $clog2(CHANNELS)  : 1;

  typedef enum logic [1:0] {IDLE, FILL, REPEAT, FINISH} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [KW-1:0]         ch;
  logic [DATA_WIDTH-1:0] hold;
  logic                  hold_v;
  logic                  dup;
  logic [DATA_WIDTH-1:0] linebuf [IN_WIDTH];

  logic col_last, row_last, ch_last;
  logic in_fire, out_fire;

  assign col_last = (col == CW'(IN_WIDTH - 1));
  assign row_last = (row == RW'(IN_HEIGHT - 1));
  assign ch_last  = (ch  == KW'(CHANNELS - 1));
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FILL;
      end
      FILL: begin
        // Back-to-back accept when the held pixel is leaving, except on the
        // last column: the next pixel belongs to a later row and must wait
        // until the replay of this row has finished.
        in_ready  = !hold_v | (dup & out_ready & !col_last);
        out_valid = hold_v;
        out_data  = hold;
        if (hold_v && out_ready && dup && col_last) state_nxt = REPEAT;
      end
      REPEAT: begin
        out_valid = 1'b1;
        out_data  = linebuf[col];
        out_last  = col_last & dup & row_last & ch_last;
        if (out_ready && dup && col_last) begin
          if (row_last && ch_last) state_nxt = FINISH;
          else                     state_nxt = FILL;
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold register, duplicate flag and col/row/ch position counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= '0;
      hold_v <= 1'b0;
      dup    <= 1'b0;
      col    <= '0;
      row    <= '0;
      ch     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hold_v <= 1'b0;
            dup    <= 1'b0;
            col    <= '0;
            row    <= '0;
            ch     <= '0;
          end
        end
        FILL: begin
          if (out_fire) begin
            if (!dup) begin
              dup <= 1'b1;
            end else begin
              dup    <= 1'b0;
              hold_v <= 1'b0;
              col    <= col_last ? '0 : col + CW'(1);
            end
          end
          // A new pixel overrides the clear above when it arrives in the same cycle.
          if (in_fire) begin
            hold   <= in_data;
            hold_v <= 1'b1;
            dup    <= 1'b0;
          end
        end
        REPEAT: begin
          if (out_fire) begin
            dup <= !dup;
            if (dup) begin
              col <= col_last ? '0 : col + CW'(1);
              if (col_last) begin
                if (!row_last) begin
                  row <= row + RW'(1);
                end else begin
                  row <= '0;
                  ch  <= ch_last ? '0 : ch + KW'(1);
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line buffer: store the held pixel as its second copy leaves, so the
  // write address is always the column the pixel belongs to.
  always_ff @(posedge clk) begin
    if (state == FILL && out_fire && dup) linebuf[col] <= hold;
  end

endmodule

// File: tb/tb_upsample2x_stream.sv
// Directed bench for upsample2x_stream: three instances (2x2x1, 2x2x2, 1x1x1) share stimulus.
// Only the selected instance is started, so the others stay idle with in_ready=0.
// Expected streams are rebuilt from the input vectors by the row-doubling rule.
module tb_upsample2x_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;
  int          sel;

  logic [15:0] od [3];
  logic        ir [3], ov [3], ol [3], bz [3], dn [3];

  logic [15:0] m_out_data;
  logic        m_in_ready, m_out_valid, m_out_last, m_busy, m_done;

  logic [15:0] in_vals [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  upsample2x_stream #(.IN_WIDTH(2), .IN_HEIGHT(2), .CHANNELS(1), .DATA_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[0]), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_last(ol[0]), .busy(bz[0]), .done(dn[0]));

  upsample2x_stream #(.IN_WIDTH(2), .IN_HEIGHT(2), .CHANNELS(2), .DATA_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[1]), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_last(ol[1]), .busy(bz[1]), .done(dn[1]));

  upsample2x_stream #(.IN_WIDTH(1), .IN_HEIGHT(1), .CHANNELS(1), .DATA_WIDTH(16)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir[2]), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_last(ol[2]), .busy(bz[2]), .done(dn[2]));

  // Route the selected instance to the checker.
  always_comb begin
    m_out_data  = od[sel];
    m_in_ready  = ir[sel];
    m_out_valid = ov[sel];
    m_out_last  = ol[sel];
    m_busy      = bz[sel];
    m_done      = dn[sel];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Runs one frame (or aborts after abort_at output words) on instance sel.
  // rdy_mode 1: out_ready toggles 1,0,... ; vld_mode 1: in_valid every third cycle.
  task automatic run_frame(input int w, input int n_in, input int rdy_mode,
                           input int vld_mode, input int abort_at, input bit glitch);
    logic [15:0] exp_q [$];
    logic [15:0] held;
    bit          stalled;
    int          ii, oo, cyc, n_out;
    ii = 0; oo = 0; cyc = 0; stalled = 0; held = '0;
    for (int q = 0; q < n_in / w; q++)
      for (int rep = 0; rep < 2; rep++)
        for (int c = 0; c < w; c++) begin
          exp_q.push_back(in_vals[q*w + c]);
          exp_q.push_back(in_vals[q*w + c]);
        end
    n_out = exp_q.size();

    @(negedge clk);
    start_v = 3'(1 << sel);
    @(negedge clk);
    start_v = '0;

    while (oo < n_out && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (ii < n_in) && (vld_mode == 0 || cyc % 3 == 0);
      in_data   = (ii < n_in) ? in_vals[ii] : 16'hdead;
      out_ready = (rdy_mode == 0) ? 1'b1 : 1'(cyc % 2);
      start_v   = (glitch && cyc == 3) ? 3'(1 << sel) : 3'b000;
      #1;
      if (stalled) begin
        check("stall_valid", 32'(m_out_valid), 32'd1);
        check("stall_data", 32'(m_out_data), 32'(held));
      end
      if (in_valid && m_in_ready) begin
        // Inputs are only taken during the first (doubled) half of a row pair.
        check("in_phase", 32'((oo % (4*w)) < 2*w), 32'd1);
        ii++;
      end
      if (m_out_valid && out_ready) begin
        check("data", 32'(m_out_data), 32'(exp_q[oo]));
        check("last", 32'(m_out_last), 32'(oo == n_out - 1));
        oo++;
        if (oo == abort_at) break;
      end
      stalled = m_out_valid && !out_ready;
      held    = m_out_data;
    end
    start_v = '0;

    if (abort_at == 0) begin
      if (cyc >= 2000) check("timeout_outputs", 32'(oo), 32'(n_out));
      check("inputs_taken", 32'(ii), 32'(n_in));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("done_pulse", 32'(m_done), 32'd1);
      check("busy_finish", 32'(m_busy), 32'd1);
      check("valid_finish", 32'(m_out_valid), 32'd0);
      @(negedge clk);
      #1;
      check("done_clear", 32'(m_done), 32'd0);
      check("busy_idle", 32'(m_busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start_v = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; sel = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_in_ready", 32'(m_in_ready), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_last", 32'(m_out_last), 32'd0);
    check("rst_data", 32'(m_out_data), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) in_vals[i] = 16'(i + 1);

    // Basic 2x2x1, full rate.
    sel = 0; run_frame(2, 4, 0, 0, 0, 1'b0);
    // Output backpressure.
    run_frame(2, 4, 1, 0, 0, 1'b0);
    // Input gaps.
    run_frame(2, 4, 0, 1, 0, 1'b0);
    // Gaps and backpressure together.
    run_frame(2, 4, 1, 1, 0, 1'b0);
    // Two channel planes.
    sel = 1; run_frame(2, 8, 0, 0, 0, 1'b0);
    // start pulsed mid-frame must be ignored.
    sel = 0; run_frame(2, 4, 0, 0, 0, 1'b1);

    // Abort after the 5th output word with a synchronous reset.
    run_frame(2, 4, 0, 0, 5, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_out_valid", 32'(m_out_valid), 32'd0);
    check("abort_in_ready", 32'(m_in_ready), 32'd0);
    check("abort_busy", 32'(m_busy), 32'd0);
    check("abort_done", 32'(m_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("abort_no_done", 32'(m_done), 32'd0);
    run_frame(2, 4, 0, 0, 0, 1'b0);

    // Degenerate 1x1x1.
    sel = 2;
    in_vals[0] = 16'hA5A5;
    run_frame(1, 1, 0, 0, 0, 1'b0);
    run_frame(1, 1, 1, 1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
